// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the instruction-cache fill controller:
//   - default values of the controller parameters
//   - fetch address field widths and bit positions (tag / index / word)
//   - fill controller state encoding (IDLE, FILL, WAIT)
//   - helper that builds a word-aligned memory address for a block word
//
// Fetch address layout (16-bit byte address):
//   [15:10] tag    [9:4] set index    [3:1] word in block    [0] byte (ignored)
// -----------------------------------------------------------------------------
package icache_pkg;

    // Default configuration of icache_fill_ctrl.
    localparam int unsigned NUM_SETS_DEF    = 64;
    localparam int unsigned BLOCK_WORDS_DEF = 8;
    localparam int unsigned MEM_LATENCY_DEF = 4;

    // Address geometry.
    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned TAG_W     = 6;
    localparam int unsigned INDEX_W   = 6;
    localparam int unsigned WORD_W    = 3;
    localparam int unsigned WORD_LSB  = 1;
    localparam int unsigned INDEX_LSB = WORD_LSB + WORD_W;
    localparam int unsigned TAG_LSB   = INDEX_LSB + INDEX_W;

    typedef logic [TAG_W-1:0]   tag_t;
    typedef logic [INDEX_W-1:0] index_t;
    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [ADDR_W-1:0]  addr_t;

    // Fill controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        WAIT = 2'd2
    } fill_state_e;

    // Word-aligned byte address of one word of a block.
    function automatic addr_t block_word_addr(
        input tag_t   tag,
        input index_t index,
        input word_t  word
    );
        return {tag, index, word, 1'b0};
    endfunction

endpackage : icache_pkg

// File: rtl/icache_tag_array.sv
// -----------------------------------------------------------------------------
// icache_tag_array
// Tag and valid storage for a direct-mapped instruction cache.
//   - asynchronous read of tag and valid bit for rd_index
//   - synchronous write of a tag, setting its valid bit, when wr_en is high
//   - synchronous clear of every valid bit while rst_n is low; tag contents
//     are not cleared (a cleared valid bit makes them irrelevant)
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   synchronous active-low clear of all valid bits
//   rd_index  in   set looked up this cycle
//   rd_tag    out  stored tag of rd_index
//   rd_valid  out  valid bit of rd_index
//   wr_en     in   install wr_tag into wr_index and mark it valid
//   wr_index  in   set being installed
//   wr_tag    in   tag being installed
// -----------------------------------------------------------------------------
module icache_tag_array
    import icache_pkg::*;
#(
    parameter int unsigned NUM_SETS = NUM_SETS_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  index_t rd_index,
    output tag_t   rd_tag,
    output logic   rd_valid,
    input  logic   wr_en,
    input  index_t wr_index,
    input  tag_t   wr_tag
);

    tag_t                tag_mem_r [NUM_SETS];
    logic [NUM_SETS-1:0] valid_r;

    // Asynchronous lookup port.
    assign rd_tag   = tag_mem_r[rd_index];
    assign rd_valid = valid_r[rd_index];

    // Valid bits: cleared by reset, which takes priority over an install on
    // the same edge so a fill cut short by reset never becomes valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= '0;
        end else if (wr_en) begin
            valid_r[wr_index] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag storage: written only on an install outside reset.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            tag_mem_r[wr_index] <= wr_tag;
        end
    end

endmodule : icache_tag_array

// File: rtl/icache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// icache_fill_ctrl
// Lookup and block-fill controller of a direct-mapped instruction cache.
// A fetch that hits in IDLE is served in the same cycle (stall=0, data-array
// address driven combinationally). A miss stalls fetch, latches {tag,index},
// then FILL issues one pipelined memory read per cycle for every word of the
// block while returned words are written into the data array; WAIT collects
// the remaining returns. The tag is installed on the edge that ends the cycle
// of the last return, so the refetch hits in the following cycle. A started
// fill always completes, whatever fetch does meanwhile.
//
// Parameters:
//   NUM_SETS     number of direct-mapped sets (64)
//   BLOCK_WORDS  16-bit words per block (8)
//   MEM_LATENCY  cycles from mem_rd to mem_data_valid (4, >= 1)
//
// Ports:
//   clk             in   clock, all state on rising edge
//   rst_n           in   synchronous active-low reset
//   fetch_req       in   fetch requests an instruction this cycle
//   fetch_addr      in   16-bit byte address, bit 0 ignored
//   stall           out  fetch must hold PC and retry
//   da_set          out  data-array set (hit read or fill write)
//   da_word         out  data-array word select
//   da_we           out  data-array write enable for a returned word
//   mem_rd          out  pipelined main-memory read request
//   mem_addr        out  word-aligned address of mem_rd
//   mem_data_valid  in   returned word present this cycle
//   hit_cnt         out  (ICACHE_PERF_EN only) wrapping hit counter
//   miss_cnt        out  (ICACHE_PERF_EN only) wrapping miss counter
//
// Build option: define ICACHE_PERF_EN to add the hit/miss counters.
// -----------------------------------------------------------------------------
module icache_fill_ctrl
    import icache_pkg::*;
#(
    parameter int unsigned NUM_SETS    = NUM_SETS_DEF,
    parameter int unsigned BLOCK_WORDS = BLOCK_WORDS_DEF,
    parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_req,
    input  logic [ADDR_W-1:0]  fetch_addr,
    output logic               stall,
    output logic [INDEX_W-1:0] da_set,
    output logic [WORD_W-1:0]  da_word,
    output logic               da_we,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_data_valid
`ifdef ICACHE_PERF_EN
    ,
    output logic [15:0]        hit_cnt,
    output logic [15:0]        miss_cnt
`endif
);

    // The port widths fix the geometry; reject a configuration that does
    // not match it.
    if ((NUM_SETS != (32'd1 << INDEX_W)) ||
        (BLOCK_WORDS != (32'd1 << WORD_W)) ||
        (MEM_LATENCY < 32'd1)) begin : g_cfg_check
        $error("icache_fill_ctrl: unsupported NUM_SETS/BLOCK_WORDS/MEM_LATENCY");
    end

    localparam word_t LAST_WORD = word_t'(BLOCK_WORDS - 32'd1);

    // Incoming address fields.
    tag_t   req_tag_s;
    index_t req_index_s;
    word_t  req_word_s;
    logic   unused_byte_s;

    // Tag array lookup result.
    tag_t   rd_tag_s;
    logic   rd_valid_s;

    // Lookup decode.
    logic   lookup_s;
    logic   hit_s;
    logic   miss_s;
    logic   fill_done_s;

    // Controller state.
    fill_state_e state_r;
    word_t       issue_cnt_r;
    word_t       rcv_cnt_r;
    tag_t        lat_tag_r;
    index_t      lat_index_r;

    assign req_tag_s     = fetch_addr[TAG_LSB   +: TAG_W];
    assign req_index_s   = fetch_addr[INDEX_LSB +: INDEX_W];
    assign req_word_s    = fetch_addr[WORD_LSB  +: WORD_W];
    assign unused_byte_s = fetch_addr[0];

    icache_tag_array #(
        .NUM_SETS (NUM_SETS)
    ) u_tag_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_index (req_index_s),
        .rd_tag   (rd_tag_s),
        .rd_valid (rd_valid_s),
        .wr_en    (fill_done_s),
        .wr_index (lat_index_r),
        .wr_tag   (lat_tag_r)
    );

    // Hit/miss decode: addresses are only looked up while IDLE.
    always_comb begin
        lookup_s = 1'b0;
        hit_s    = 1'b0;
        miss_s   = 1'b0;
        if (state_r == IDLE) begin
            lookup_s = fetch_req;
        end else begin
            lookup_s = 1'b0;
        end
        if (lookup_s && rd_valid_s && (rd_tag_s == req_tag_s)) begin
            hit_s  = 1'b1;
            miss_s = 1'b0;
        end else if (lookup_s) begin
            hit_s  = 1'b0;
            miss_s = 1'b1;
        end else begin
            hit_s  = 1'b0;
            miss_s = 1'b0;
        end
    end

    // Last returned word of the block arrives this cycle.
    assign fill_done_s = (state_r == WAIT) && mem_data_valid && (rcv_cnt_r == LAST_WORD);

    // Output decode from the registered state; hits and returned words are
    // reflected in the same cycle they occur.
    always_comb begin
        stall    = 1'b0;
        da_set   = req_index_s;
        da_word  = req_word_s;
        da_we    = 1'b0;
        mem_rd   = 1'b0;
        mem_addr = {ADDR_W{1'b0}};
        case (state_r)
            IDLE: begin
                stall   = miss_s;
                da_set  = req_index_s;
                da_word = req_word_s;
            end
            FILL: begin
                stall    = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = block_word_addr(lat_tag_r, lat_index_r, issue_cnt_r);
                da_set   = lat_index_r;
                da_word  = rcv_cnt_r;
                da_we    = mem_data_valid;
            end
            WAIT: begin
                stall   = 1'b1;
                da_set  = lat_index_r;
                da_word = rcv_cnt_r;
                da_we   = mem_data_valid;
            end
            default: begin
                stall = 1'b1;
            end
        endcase
    end

    // Fill sequencer: latch the missing block, issue every request, count
    // every return, and return to IDLE on the last return.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            issue_cnt_r <= '0;
            rcv_cnt_r   <= '0;
            lat_tag_r   <= '0;
            lat_index_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (miss_s) begin
                        lat_tag_r   <= req_tag_s;
                        lat_index_r <= req_index_s;
                        issue_cnt_r <= '0;
                        rcv_cnt_r   <= '0;
                        state_r     <= FILL;
                    end
                end
                FILL: begin
                    // Early returns (short latency) overlap the request burst.
                    issue_cnt_r <= issue_cnt_r + 3'd1;
                    if (mem_data_valid) begin
                        rcv_cnt_r <= rcv_cnt_r + 3'd1;
                    end
                    if (issue_cnt_r == LAST_WORD) begin
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_data_valid) begin
                        rcv_cnt_r <= rcv_cnt_r + 3'd1;
                        if (rcv_cnt_r == LAST_WORD) begin
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    issue_cnt_r <= '0;
                    rcv_cnt_r   <= '0;
                end
            endcase
        end
    end

`ifdef ICACHE_PERF_EN
    logic [15:0] hit_cnt_r;
    logic [15:0] miss_cnt_r;

    // Performance counters: one count per hit cycle and per miss detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_r  <= 16'd0;
            miss_cnt_r <= 16'd0;
        end else begin
            if (hit_s) begin
                hit_cnt_r <= hit_cnt_r + 16'd1;
            end
            if (miss_s) begin
                miss_cnt_r <= miss_cnt_r + 16'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_r;
    assign miss_cnt = miss_cnt_r;
`endif

endmodule : icache_fill_ctrl

// File: tb/tb_icache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icache_fill_ctrl
// Directed scenarios followed by randomized fetch traffic. A memory responder
// returns mem_data_valid MEM_LATENCY cycles after each mem_rd. The reference
// model tracks the cache as arrays of valid bits and tags plus a fill
// described by the cycle of its miss and the number of words returned.
// -----------------------------------------------------------------------------
module tb_icache_fill_ctrl;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        stall;
    logic [5:0]  da_set;
    logic [2:0]  da_word;
    logic        da_we;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_data_valid;
`ifdef ICACHE_PERF_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    icache_fill_ctrl #(
        .NUM_SETS    (64),
        .BLOCK_WORDS (8),
        .MEM_LATENCY (LAT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_req      (fetch_req),
        .fetch_addr     (fetch_addr),
        .stall          (stall),
        .da_set         (da_set),
        .da_word        (da_word),
        .da_we          (da_we),
        .mem_rd         (mem_rd),
        .mem_addr       (mem_addr),
        .mem_data_valid (mem_data_valid)
`ifdef ICACHE_PERF_EN
        ,
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state.
    bit          vld_m [64];
    logic [5:0]  tag_m [64];
    bit          busy_m = 1'b0;
    int          miss_cyc_m = 0;
    logic [5:0]  ftag_m = 6'd0;
    logic [5:0]  fidx_m = 6'd0;
    int          nret_m = 0;
    logic [15:0] hits_m = 16'd0;
    logic [15:0] misses_m = 16'd0;
    int          cyc = 0;
    logic [LAT-1:0] pipe = '0;
    bit          chk_en = 1'b0;

    // Per-cycle snapshots and counters for directed checks.
    logic        s_stall, s_we, s_rd;
    logic [5:0]  s_set;
    logic [2:0]  s_word;
    logic [15:0] s_hcnt, s_mcnt;
    int          n_rd = 0;
    int          n_we = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", name, obs, exp, cyc);
        end
    endtask

    // One clock cycle: inputs are already applied; check, clock, update model
    // and memory responder.
    task automatic cycle();
        logic [5:0] t, ix;
        logic [2:0] w;
        bit hit, miss, e_rd, e_we;
        int k;
        logic r_rst, r_mdv, rd_seen;
        #3;
        t  = fetch_addr[15:10];
        ix = fetch_addr[9:4];
        w  = fetch_addr[3:1];
        hit = 1'b0; miss = 1'b0; e_rd = 1'b0; e_we = 1'b0; k = 0;
        if (!busy_m) begin
            hit  = fetch_req && vld_m[ix] && (tag_m[ix] == t);
            miss = fetch_req && !hit;
        end else begin
            k    = cyc - miss_cyc_m;
            e_rd = (k >= 1) && (k <= 8);
            e_we = mem_data_valid;
        end
        s_stall = stall; s_we = da_we; s_rd = mem_rd; s_set = da_set; s_word = da_word;
`ifdef ICACHE_PERF_EN
        s_hcnt = hit_cnt; s_mcnt = miss_cnt;
`else
        s_hcnt = 16'd0; s_mcnt = 16'd0;
`endif
        if (chk_en) begin
            chk("stall", 32'(stall), 32'(busy_m || miss));
            chk("mem_rd", 32'(mem_rd), 32'(e_rd));
            chk("da_we", 32'(da_we), 32'(e_we));
            if (hit) begin
                chk("hit_set", 32'(da_set), 32'(ix));
                chk("hit_word", 32'(da_word), 32'(w));
            end
            if (e_rd) chk("mem_addr", 32'(mem_addr), 32'({ftag_m, fidx_m, 3'(k - 1), 1'b0}));
            if (e_we) begin
                chk("fill_set", 32'(da_set), 32'(fidx_m));
                chk("fill_word", 32'(da_word), 32'(nret_m % 8));
            end
`ifdef ICACHE_PERF_EN
            chk("hit_cnt", 32'(hit_cnt), 32'(hits_m));
            chk("miss_cnt", 32'(miss_cnt), 32'(misses_m));
`endif
        end
        if (mem_rd === 1'b1) n_rd++;
        if (da_we === 1'b1) n_we++;
        r_rst = rst_n; r_mdv = mem_data_valid; rd_seen = mem_rd;
        @(posedge clk);
        if (!r_rst) begin
            for (int i = 0; i < 64; i++) vld_m[i] = 1'b0;
            busy_m = 1'b0; nret_m = 0; hits_m = 16'd0; misses_m = 16'd0;
        end else begin
            if (hit) hits_m = hits_m + 16'd1;
            if (miss) begin
                misses_m = misses_m + 16'd1;
                busy_m = 1'b1; miss_cyc_m = cyc; ftag_m = t; fidx_m = ix; nret_m = 0;
            end else if (busy_m && r_mdv) begin
                nret_m++;
                if (nret_m == 8) begin
                    vld_m[fidx_m] = 1'b1;
                    tag_m[fidx_m] = ftag_m;
                    busy_m = 1'b0;
                end
            end
        end
        #1;
        pipe = {pipe[LAT-2:0], rd_seen};
        mem_data_valid = pipe[LAT-1];
        cyc++;
    endtask

    // Hold the current fetch until it is served; returns the stall count.
    task automatic run_until_hit(output int n);
        bit done;
        n = 0; done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            cycle();
            if (s_stall === 1'b0) done = 1'b1;
            else n++;
        end
        if (!done) chk("hit_timeout", 32'd1, 32'd0);
    endtask

    function automatic logic [15:0] rand_addr();
        logic [5:0] t, ix;
        logic [2:0] w;
        logic b;
        int sel;
        t   = 6'($urandom_range(0, 2));
        sel = $urandom_range(0, 3);
        ix  = (sel == 0) ? 6'd0 : (sel == 1) ? 6'd1 : (sel == 2) ? 6'h23 : 6'($urandom_range(0, 63));
        w   = 3'($urandom_range(0, 7));
        b   = 1'($urandom_range(0, 1));
        return {t, ix, w, b};
    endfunction

    initial begin
        int n;
        rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = 16'h0000; mem_data_valid = 1'b0;
        cycle(); cycle();
        rst_n = 1'b1; chk_en = 1'b1;

        // Reset state: idle outputs.
        cycle();
        chk("rst_stall", 32'(s_stall), 32'd0);
        chk("rst_mem_rd", 32'(s_rd), 32'd0);
        chk("rst_da_we", 32'(s_we), 32'd0);

        // Cold start on 0x0000: 13 stall cycles, 8 requests, 8 writes.
        n_rd = 0; n_we = 0;
        fetch_req = 1'b1; fetch_addr = 16'h0000;
        run_until_hit(n);
        chk("cold_stall_cycles", 32'(n), 32'd13);
        chk("cold_requests", 32'(n_rd), 32'd8);
        chk("cold_writes", 32'(n_we), 32'd8);
        chk("cold_hit_set", 32'(s_set), 32'd0);

        // Hit on 0x0006.
        fetch_addr = 16'h0006;
        cycle();
        chk("h6_stall", 32'(s_stall), 32'd0);
        chk("h6_set", 32'(s_set), 32'd0);
        chk("h6_word", 32'(s_word), 32'd3);
        chk("h6_mem_rd", 32'(s_rd), 32'd0);

        // Conflict: 0x0400 evicts 0x0000, which then misses again.
        fetch_addr = 16'h0400;
        run_until_hit(n);
        chk("conf_400_stalls", 32'(n), 32'd13);
        fetch_addr = 16'h0000;
        run_until_hit(n);
        chk("conf_000_stalls", 32'(n), 32'd13);

        // Reset in fill cycle 6.
        fetch_addr = 16'h0400;
        for (int i = 0; i < 6; i++) cycle();
        rst_n = 1'b0;
        cycle();
        chk("rstfill_rd_during", 32'(s_rd), 32'd1);
        rst_n = 1'b1; fetch_req = 1'b0; n_we = 0;
        cycle();
        chk("rstfill_rd_after", 32'(s_rd), 32'd0);
        chk("rstfill_stall_after", 32'(s_stall), 32'd0);
        repeat (5) cycle();
        chk("rstfill_late_writes", 32'(n_we), 32'd0);
        fetch_req = 1'b1; fetch_addr = 16'h0000;
        run_until_hit(n);
        chk("rstfill_refetch", 32'(n), 32'd13);

        // Redirect to 0x1230 in fill cycle 3.
        fetch_addr = 16'h0400;
        run_until_hit(n);
        fetch_addr = 16'h0000;
        cycle(); cycle(); cycle();
        fetch_addr = 16'h1230;
        run_until_hit(n);
        chk("redir_stalls", 32'(n), 32'd23);
        chk("redir_set", 32'(s_set), 32'h23);
        fetch_addr = 16'h0000;
        cycle();
        chk("redir_old_block_hit", 32'(s_stall), 32'd0);

`ifdef ICACHE_PERF_EN
        // One miss plus five hits.
        rst_n = 1'b0; fetch_req = 1'b0;
        cycle();
        rst_n = 1'b1; fetch_req = 1'b1; fetch_addr = 16'h0000;
        run_until_hit(n);
        repeat (4) cycle();
        fetch_req = 1'b0;
        cycle();
        chk("perf_miss_cnt", 32'(s_mcnt), 32'd1);
        chk("perf_hit_cnt", 32'(s_hcnt), 32'd5);
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0; fetch_req = 1'($urandom_range(0, 1));
                cycle();
                rst_n = 1'b1; fetch_req = 1'b0;
                repeat (6) cycle();
            end else begin
                fetch_req  = ($urandom_range(0, 3) != 0);
                fetch_addr = rand_addr();
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_icache_fill_ctrl

// File: doc/icache_fill_ctrl.md
ICACHE_FILL_CTRL -- requirements
Module: icache_fill_ctrl

Interface
REQ-001 SHALL have parameter NUM_SETS, default 64, number of direct-mapped sets.
REQ-002 SHALL have parameter BLOCK_WORDS, default 8, 16-bit words per block (16 bytes).
REQ-003 SHALL have parameter MEM_LATENCY, default 4, cycles from mem_rd to mem_data_valid.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port fetch_req  input  1  fetch stage requests an instruction this cycle.
REQ-007 SHALL have port fetch_addr  input  16  byte address from PC register; bit 0 ignored.
REQ-008 SHALL have port stall  output  1  fetch must hold PC and retry.
REQ-009 SHALL have port da_set  output  6  data-array set index (hit read or fill write).
REQ-010 SHALL have port da_word  output  3  data-array word select.
REQ-011 SHALL have port da_we  output  1  data-array write enable for fill word.
REQ-012 SHALL have port mem_rd  output  1  pipelined main-memory read request.
REQ-013 SHALL have port mem_addr  output  16  word-aligned address of mem_rd.
REQ-014 SHALL have port mem_data_valid  input  1  returned word present (data routed to data array externally).

Function
REQ-015 SHALL split fetch_addr as tag[15:10], index[9:4], word[3:1].
REQ-016 SHALL declare hit when fetch_req, state IDLE, valid[index]=1, tag_arr[index]=tag; stall=0, da_set=index, da_word=word, same cycle.
REQ-017 SHALL assert stall combinationally on a miss in IDLE, and in every cycle while state is not IDLE.
REQ-018 SHALL on a miss latch {tag,index}, and move IDLE->FILL on the next edge.
REQ-019 SHALL in FILL issue mem_rd=1 for exactly BLOCK_WORDS consecutive cycles, mem_addr={tag,index,issue_cnt,1'b0}, issue_cnt 0..7.
REQ-020 SHALL count returns with rcv_cnt 0..7; each mem_data_valid in FILL/WAIT drives da_we=1, da_set=latched index, da_word=rcv_cnt.
REQ-021 SHALL move FILL->WAIT after the 8th request, and WAIT->IDLE on the edge ending the cycle with the 8th mem_data_valid, writing tag_arr and setting valid on that same edge.
REQ-022 SHALL yield, for MEM_LATENCY=4, miss in cycle 0, requests cycles 1-8, returns cycles 5-12, hit with stall=0 in cycle 13 (13 stall cycles).
REQ-023 SHALL complete a started fill regardless of fetch_req or fetch_addr changes (e.g. branch redirect); the new address is looked up only in IDLE.
REQ-024 SHALL ignore mem_data_valid in IDLE (no da_we).
REQ-025 SHALL hold mem_rd=0 and da_we=0 whenever not in FILL/WAIT respectively.

Reset
REQ-026 SHALL on rst_n=0 at a clock edge: state IDLE, all valid bits 0, issue_cnt=rcv_cnt=0, latched tag/index 0.
REQ-027 SHALL force mem_rd=0, da_we=0 in the cycle after reset is sampled, including reset mid-fill; tag contents need not be cleared.
REQ-028 SHALL not set valid for a block whose fill was cut by reset.

Configuration
REQ-029 SHALL, with ICACHE_PERF_EN defined, add outputs hit_cnt and miss_cnt (16 bits each, wrapping, reset 0) incrementing once per hit cycle and once per miss detection in IDLE.
REQ-030 SHALL, without ICACHE_PERF_EN, have no counter ports or logic.

Structure
REQ-031 SHALL place tag/index/word widths, state enum (IDLE, FILL, WAIT), and default parameter values in shared package icache_pkg.
REQ-032 SHALL implement tag and valid storage in one sub-module icache_tag_array (async read, sync write, sync valid clear).

Verification
REQ-033 Cold start, fetch 0x0000 -> stall 13 cycles, mem_addr 0x0000..0x000E cycles 1-8, da_we cycles 5-12 words 0-7, cycle 13 hit.
REQ-034 After fill, fetch 0x0006 -> stall=0, da_set=0, da_word=3, mem_rd=0.
REQ-035 Fetch 0x0400 (index 0, tag 1) after 0x0000 fill -> miss, refill; subsequent 0x0000 misses again.
REQ-036 Reset asserted in fill cycle 6 -> mem_rd=0 next cycle, late mem_data_valid ignored, refetch 0x0000 misses.
REQ-037 fetch_addr changes to 0x1230 at fill cycle 3 -> 0x0000 block completes, then 0x1230 misses and fills set 0x23.
REQ-038 With ICACHE_PERF_EN, 1 miss plus 5 hits -> miss_cnt=1, hit_cnt=5 (hit in cycle 13 counted).
